// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: oversampled UART receiver for 8-N-1 frames on the 1 MHz system clock.
// Each start edge is confirmed at half a bit period.
// Later bits are sampled one full period apart, so every sample lands mid-bit.
// Optional macro UART_RX_PARITY_EN switches the frame to 8-E-1.
// That build adds a parity bit between data bit 7 and the stop bit.
module uart_rx_8n1 #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk_1MHz,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] outData,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfM1 = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullM1 = CntW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   par_ok;

`ifdef UART_RX_PARITY_EN
  logic par_err_q, par_err_d;
  assign par_ok = ~par_err_q;
`else
  assign par_ok = 1'b1;
`endif

  // Synchronizer for the asynchronous line; flops reset to the idle (high) level.
  always_ff @(posedge clk_1MHz or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  // State register and datapath flops.
  always_ff @(posedge clk_1MHz or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  // Next-state logic: bit timing, sampling, and strobe generation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d = par_err_q;
`endif
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        // A line still low after a failed stop bit re-enters START at once.
        if (!rx_s) begin
          state_d   = StStart;
          bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
          par_err_d = 1'b0;
`endif
        end
      end
      StStart: begin
        if (cnt_q == HalfM1) begin
          cnt_d   = '0;
          // A high line at mid start bit was only a glitch.
          state_d = rx_s ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == FullM1) begin
          cnt_d            = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (cnt_q == FullM1) begin
          cnt_d   = '0;
          state_d = StStop;
          // Even parity: data ones plus the parity bit must be even.
          if (^shift_q ^ rx_s) begin
            par_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      StStop: begin
        if (cnt_q == FullM1) begin
          cnt_d   = '0;
          state_d = StIdle;
          if (rx_s && par_ok) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  assign outData   = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != StIdle);

endmodule
